// File: rtl/ddr_cache_pkg.sv
// Shared types and widths for the DDR line cache.
// Line geometry, memory address width, FSM encoding and the byte-merge helper.
package ddr_cache_pkg;

    localparam int LINE_W     = 256;
    localparam int WORD_OFF_W = 3;
    localparam int MEM_AW     = 30;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        REFILL
    } state_e;

    function automatic logic [LINE_W-1:0] merge_word(
        input logic [LINE_W-1:0]     line,
        input logic [WORD_OFF_W-1:0] off,
        input logic [31:0]           wdata,
        input logic [3:0]            be
    );
        logic [LINE_W-1:0] res;
        res = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[{off, 2'(b), 3'b000} +: 8] = wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ddr_cache_array.sv
// Line storage for the DDR line cache: valid/dirty/tag/data per line.
// Combinational read by index, one write port (full line or byte-masked word).
module ddr_cache_array
    import ddr_cache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IW    = $clog2(LINES),
    parameter int TW    = MEM_AW - WORD_OFF_W - IW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IW-1:0]         rd_idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TW-1:0]         rd_tag,
    output logic [LINE_W-1:0]     rd_line,
    input  logic                  wr_en,
    input  logic                  wr_full,
    input  logic [IW-1:0]         wr_idx,
    input  logic [TW-1:0]         wr_tag,
    input  logic [LINE_W-1:0]     wr_line,
    input  logic [WORD_OFF_W-1:0] wr_off,
    input  logic [31:0]           wr_word,
    input  logic [3:0]            wr_be
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [LINES-1:0]  dirty_q;
    logic [LINES-1:0]  dirty_d;
    logic [TW-1:0]     tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    logic [LINE_W-1:0] line_d;

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        line_d  = wr_full ? wr_line
                          : merge_word(data_q[wr_idx], wr_off, wr_word, wr_be);
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            // A refill leaves the line clean; any word write dirties it.
            dirty_d[wr_idx] = ~wr_full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx] <= line_d;
            if (wr_full) begin
                tag_q[wr_idx] <= wr_tag;
            end
        end
    end

endmodule

// File: rtl/ddr_line_cache.sv
// Direct-mapped write-back line cache between CPU data port and DDR block port.
// Optional hit/miss counters enabled by defining DDR_CACHE_STATS_EN.
module ddr_line_cache
    import ddr_cache_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_en,
    input  logic         cpu_we,
    input  logic [29:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    input  logic [3:0]   cpu_be,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_stall,
    output logic         mem_en,
    output logic         mem_write,
    output logic [29:0]  mem_addr,
    output logic [255:0] mem_wdata,
    input  logic         mem_rdy,
    input  logic [255:0] mem_rdata
`ifdef DDR_CACHE_STATS_EN
    ,
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_misses
`endif
);

    localparam int IW = $clog2(LINES);
    localparam int TW = MEM_AW - WORD_OFF_W - IW;

    logic [WORD_OFF_W-1:0] cpu_off;
    logic [IW-1:0]         cpu_idx;
    logic [TW-1:0]         cpu_tag;

    assign cpu_off = cpu_addr[WORD_OFF_W-1:0];
    assign cpu_idx = cpu_addr[WORD_OFF_W +: IW];
    assign cpu_tag = cpu_addr[MEM_AW-1 -: TW];

    state_e            state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_write_q, mem_write_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] fill_q, fill_d;
    logic              first_q, first_d;
    logic [IW-1:0]     req_idx_q, req_idx_d;
    logic [TW-1:0]     req_tag_q, req_tag_d;

    logic              rd_valid;
    logic              rd_dirty;
    logic [TW-1:0]     rd_tag;
    logic [LINE_W-1:0] rd_line;
    logic              wr_en;
    logic              wr_full;
    logic [IW-1:0]     wr_idx;
    logic              hit;
    logic              miss_start;

    ddr_cache_array #(
        .LINES (LINES)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (cpu_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_full  (wr_full),
        .wr_idx   (wr_idx),
        .wr_tag   (req_tag_q),
        .wr_line  (fill_q),
        .wr_off   (cpu_off),
        .wr_word  (cpu_wdata),
        .wr_be    (cpu_be)
    );

    assign hit       = cpu_en & rd_valid & (rd_tag == cpu_tag);
    assign cpu_stall = cpu_en & ((state_q != IDLE) | ~hit);
    assign cpu_rdata = rd_line[{cpu_off, 5'b00000} +: 32];
    assign wr_idx    = (state_q == REFILL) ? req_idx_q : cpu_idx;

    assign mem_en    = mem_en_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_d      = fill_q;
        first_d     = 1'b0;
        req_idx_d   = req_idx_q;
        req_tag_d   = req_tag_q;
        wr_en       = 1'b0;
        wr_full     = 1'b0;
        miss_start  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit & cpu_we) begin
                    wr_en = 1'b1;
                end else if (cpu_en & ~hit) begin
                    // Latch the miss target so the fill survives cpu_en dropping.
                    miss_start = 1'b1;
                    first_d    = 1'b1;
                    req_idx_d  = cpu_idx;
                    req_tag_d  = cpu_tag;
                    mem_en_d   = 1'b1;
                    if (rd_valid & rd_dirty) begin
                        state_d     = WB;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {rd_tag, cpu_idx, 3'b000};
                        mem_wdata_d = rd_line;
                    end else begin
                        state_d     = FILL;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {cpu_tag, cpu_idx, 3'b000};
                    end
                end
            end
            WB: begin
                if (~first_q & mem_rdy) begin
                    state_d     = FILL;
                    first_d     = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {req_tag_q, req_idx_q, 3'b000};
                end
            end
            FILL: begin
                if (~first_q & mem_rdy) begin
                    state_d  = REFILL;
                    mem_en_d = 1'b0;
                    fill_d   = mem_rdata;
                end
            end
            REFILL: begin
                wr_en   = 1'b1;
                wr_full = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_q      <= '0;
            first_q     <= 1'b0;
            req_idx_q   <= '0;
            req_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fill_q      <= fill_d;
            first_q     <= first_d;
            req_idx_q   <= req_idx_d;
            req_tag_q   <= req_tag_d;
        end
    end

`ifdef DDR_CACHE_STATS_EN
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;

    always_comb begin
        hits_d   = hits_q + {31'b0, cpu_en & ~cpu_stall};
        misses_d = misses_q + {31'b0, miss_start};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_ddr_line_cache.sv
// Self-checking bench for ddr_line_cache: memory stub plus word-level reference.
// Reference tracks architectural memory and a line-presence map to predict stalls.
module tb_ddr_line_cache;

    localparam int LINES = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_en = 1'b0;
    logic         cpu_we = 1'b0;
    logic [29:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [3:0]   cpu_be = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_en;
    logic         mem_write;
    logic [29:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_rdy = 1'b0;
    logic [255:0] mem_rdata = '0;
`ifdef DDR_CACHE_STATS_EN
    logic [31:0]  stat_hits;
    logic [31:0]  stat_misses;
`endif

    ddr_line_cache #(.LINES(LINES)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_en    (mem_en),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdy   (mem_rdy),
        .mem_rdata (mem_rdata)
`ifdef DDR_CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int lat = 2;
    int exp_hits = 0;
    int exp_misses = 0;

    logic [255:0] smem [int];
    logic [31:0]  ref_mem [int];
    bit           m_valid [LINES];
    bit           m_dirty [LINES];
    int           m_tag [LINES];

    logic         log_we [$];
    logic [29:0]  log_addr [$];
    logic [255:0] log_data [$];

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return ({2'b00, a} * 32'h9E37_79B9) ^ 32'h0F0F_1234;
    endfunction

    function automatic logic [255:0] stub_line(input int la);
        logic [255:0] l;
        if (smem.exists(la)) return smem[la];
        for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(30'(la * 8 + w));
        return l;
    endfunction

    function automatic logic [31:0] get_ref(input logic [29:0] a);
        logic [255:0] l;
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        l = stub_line(int'(a) / 8);
        return l[32*(int'(a) % 8) +: 32];
    endfunction

    // Memory stub: rdy rises on request cycle `lat`; completion logged at the edge it takes.
    int          req_cyc = 0;
    logic        prev_en = 1'b0;
    logic        prev_we = 1'b0;
    logic [29:0] prev_addr = '0;

    always @(negedge clk) begin
        if (mem_en) begin
            if (!prev_en || mem_write != prev_we || mem_addr != prev_addr) req_cyc = 1;
            else req_cyc++;
            mem_rdy = (req_cyc >= lat);
            if (!mem_write) mem_rdata = stub_line(int'(mem_addr) / 8);
            if (req_cyc >= 2 && mem_rdy) begin
                log_we.push_back(mem_write);
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
                if (mem_write) smem[int'(mem_addr) / 8] = mem_wdata;
            end
        end else begin
            req_cyc = 0;
            mem_rdy = 1'b0;
        end
        prev_en = mem_en;
        prev_we = mem_write;
        prev_addr = mem_addr;
    end

    task automatic do_access(input logic we, input logic [29:0] a,
                             input logic [31:0] wd, input logic [3:0] be,
                             input string nm, output logic [31:0] rd);
        int idx, tg, lc, exp_stall, cnt;
        logic [31:0] exp_rd, nw;
        idx = int'(a[8:3]);
        tg = int'(a[29:9]);
        lc = (lat < 2) ? 2 : lat;
        if (m_valid[idx] && m_tag[idx] == tg) exp_stall = 0;
        else if (m_valid[idx] && m_dirty[idx]) exp_stall = 2 * lc + 2;
        else exp_stall = lc + 2;
        exp_rd = get_ref(a);
        cpu_en = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        cpu_be = be;
        cnt = 0;
        #1;
        while (cpu_stall && cnt < 500) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        rd = cpu_rdata;
        n_checks++;
        if (cnt !== exp_stall)
            $display("FAIL %s stall: got %0d cycles, expected %0d", nm, cnt, exp_stall);
        else n_pass++;
        if (!we) begin
            n_checks++;
            if (cpu_rdata !== exp_rd)
                $display("FAIL %s rdata @%h: got %h, expected %h", nm, a, cpu_rdata, exp_rd);
            else n_pass++;
        end
        if (exp_stall != 0) begin
            exp_misses++;
            m_dirty[idx] = 1'b0;
        end
        exp_hits++;
        m_valid[idx] = 1'b1;
        m_tag[idx] = tg;
        if (we) begin
            m_dirty[idx] = 1'b1;
            nw = exp_rd;
            for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
            ref_mem[int'(a)] = nw;
        end
        @(posedge clk);
        @(negedge clk);
        cpu_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mem_en !== 1'b0) $display("FAIL reset mem_en: got %b, expected 0", mem_en);
        else n_pass++;
        n_checks++;
        if (mem_write !== 1'b0) $display("FAIL reset mem_write: got %b, expected 0", mem_write);
        else n_pass++;
        n_checks++;
        if (mem_addr !== 30'h0) $display("FAIL reset mem_addr: got %h, expected 0", mem_addr);
        else n_pass++;
        n_checks++;
        if (mem_wdata !== 256'h0) $display("FAIL reset mem_wdata: got %h, expected 0", mem_wdata);
        else n_pass++;
        n_checks++;
        if (cpu_stall !== 1'b0) $display("FAIL reset idle stall: got %b, expected 0", cpu_stall);
        else n_pass++;
        cpu_en = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 30'h10;
        #1;
        n_checks++;
        if (cpu_stall !== 1'b1) $display("FAIL reset cold stall: got %b, expected 1", cpu_stall);
        else n_pass++;
`ifdef DDR_CACHE_STATS_EN
        n_checks++;
        if (stat_hits !== 0 || stat_misses !== 0)
            $display("FAIL reset stats: got %0d/%0d, expected 0/0", stat_hits, stat_misses);
        else n_pass++;
`endif
        @(negedge clk);
        rst = 1'b0;
        cpu_en = 1'b0;
    endtask

    task automatic test_first_fill();
        logic [31:0] rd;
        lat = 5;
        log_we.delete(); log_addr.delete(); log_data.delete();
        do_access(1'b0, 30'h10, 32'h0, 4'h0, "first_fill", rd);
        n_checks++;
        if (log_addr.size() != 1 || log_we[0] !== 1'b0 || log_addr[0] !== 30'h10)
            $display("FAIL first_fill request: got %0d requests, expected one FILL at 0x10", log_addr.size());
        else n_pass++;
    endtask

    task automatic test_write_hit();
        logic [31:0] rd, w;
        lat = 5;
        log_we.delete(); log_addr.delete(); log_data.delete();
        do_access(1'b1, 30'h11, 32'hDEAD_BEEF, 4'b0011, "write_hit", rd);
        do_access(1'b0, 30'h11, 32'h0, 4'h0, "read_merged", rd);
        w = init_word(30'h11);
        n_checks++;
        if (rd !== {w[31:16], 16'hBEEF})
            $display("FAIL merged word: got %h, expected %h", rd, {w[31:16], 16'hBEEF});
        else n_pass++;
        n_checks++;
        if (log_addr.size() != 0)
            $display("FAIL write_hit mem traffic: got %0d requests, expected 0", log_addr.size());
        else n_pass++;
    endtask

    task automatic test_writeback();
        logic [31:0] rd;
        logic [255:0] exp_line;
        for (int w = 0; w < 8; w++) exp_line[32*w +: 32] = get_ref(30'(16 + w));
        lat = 3;
        log_we.delete(); log_addr.delete(); log_data.delete();
        do_access(1'b0, 30'h210, 32'h0, 4'h0, "dirty_miss", rd);
        n_checks++;
        if (log_addr.size() != 2)
            $display("FAIL wb request count: got %0d, expected 2", log_addr.size());
        else begin
            n_pass++;
            n_checks++;
            if (log_we[0] !== 1'b1 || log_addr[0] !== 30'h10 || log_data[0] !== exp_line)
                $display("FAIL wb request: got we=%b addr=%h data=%h, expected we=1 addr=010 data=%h",
                         log_we[0], log_addr[0], log_data[0], exp_line);
            else n_pass++;
            n_checks++;
            if (log_we[1] !== 1'b0 || log_addr[1] !== 30'h210)
                $display("FAIL wb fill: got we=%b addr=%h, expected we=0 addr=210", log_we[1], log_addr[1]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_fill();
        logic [31:0] rd;
        int base;
        lat = 30;
        cpu_en = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 30'h10;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (mem_en !== 1'b0) $display("FAIL reset_in_fill mem_en: got %b, expected 0", mem_en);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        cpu_en = 1'b0;
        // Dirty cached data is lost on reset; the architectural view reverts to memory.
        for (int i = 0; i < LINES; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                base = m_tag[i] * 512 + i * 8;
                for (int w = 0; w < 8; w++) ref_mem[base + w] = get_ref(30'(base + w));
            end
        end
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_hits = 0;
        exp_misses = 0;
        lat = 3;
        do_access(1'b0, 30'h10, 32'h0, 4'h0, "reread_after_reset", rd);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        lat = 2;
        log_we.delete(); log_addr.delete(); log_data.delete();
        do_access(1'b0, 30'h400, 32'h0, 4'h0, "b2b_first", rd);
        do_access(1'b0, 30'h405, 32'h0, 4'h0, "b2b_second", rd);
        n_checks++;
        if (log_addr.size() != 1)
            $display("FAIL b2b fills: got %0d requests, expected 1", log_addr.size());
        else n_pass++;
    endtask

    task automatic test_drop_en();
        logic [31:0] rd;
        lat = 3;
        cpu_en = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 30'hA08;
        repeat (2) @(negedge clk);
        cpu_en = 1'b0;
        cpu_addr = 30'h3FFF_FFFF;
        repeat (12) @(negedge clk);
        m_valid[1] = 1'b1;
        m_tag[1] = 5;
        m_dirty[1] = 1'b0;
        exp_misses++;
        do_access(1'b0, 30'hA0B, 32'h0, 4'h0, "drop_en_rehit", rd);
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [29:0] a;
        int tg;
        for (int n = 0; n < 150; n++) begin
            lat = $urandom_range(1, 4);
            tg = ($urandom_range(0, 9) == 0) ? 32'h1F_FFFF : $urandom_range(0, 3);
            a = 30'(tg * 512 + $urandom_range(0, 3) * 8 + $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            do_access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "random", rd);
        end
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_write_hit();
        test_writeback();
        test_reset_fill();
        test_back_to_back();
        test_drop_en();
        test_random();
`ifdef DDR_CACHE_STATS_EN
        n_checks++;
        if (stat_hits !== 32'(exp_hits))
            $display("FAIL stat_hits: got %0d, expected %0d", stat_hits, exp_hits);
        else n_pass++;
        n_checks++;
        if (stat_misses !== 32'(exp_misses))
            $display("FAIL stat_misses: got %0d, expected %0d", stat_misses, exp_misses);
        else n_pass++;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/ddr_line_cache.md
# ddr_line_cache

Direct-mapped, write-back line cache between the CPU data port and the DDR block controller. It serves 32-bit word accesses from an on-chip array of 256-bit lines. On a miss it writes back the dirty victim and refills the line through the controller's 256-bit block interface. All logic runs in the controller's `ui_clk` domain.

## Interface
- `LINES`, default 64: number of lines; power of two, 2..256.
- `clk` in 1: the controller's `ui_clk`.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_en` in 1: access request, held until `cpu_stall` is low.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 30: word address.
- `cpu_wdata` in 32: write data.
- `cpu_be` in 4: byte enables for writes.
- `cpu_rdata` out 32: read data, valid when `cpu_en & ~cpu_stall & ~cpu_we`.
- `cpu_stall` out 1: combinational; CPU must hold its request while high.
- `mem_en` out 1: block request to the controller (registered).
- `mem_write` out 1: 1 = block write (registered).
- `mem_addr` out 30: line-aligned word address, `[2:0]` = 0 (registered).
- `mem_wdata` out 256: victim line (registered).
- `mem_rdy` in 1: controller idle/complete.
- `mem_rdata` in 256: fetched line.
- `stat_hits`, `stat_misses` out 32 each: present only with `DDR_CACHE_STATS_EN`.

## Operation
- Address split: offset = `cpu_addr[2:0]` (word in line, word 0 at bits `[31:0]`). Index = next `IW = log2(LINES)` bits. Tag = `cpu_addr[29:3+IW]`.
- Per line state: valid, dirty, tag, 256-bit data.
- FSM states: `IDLE`, `WB`, `FILL`, `REFILL`.
- **IDLE, hit**
  - Hit = `cpu_en`, line valid and tag match.
  - Read: `cpu_rdata` = selected word, `cpu_stall` = 0.
  - Write: bytes merged per `cpu_be` at the clock edge, dirty set, `cpu_stall` = 0.
- **IDLE, miss**
  - Victim valid and dirty: go to `WB`. Drive `mem_en=1`, `mem_write=1`, `mem_addr={victim_tag,index,3'b0}`, `mem_wdata`=victim line.
  - Otherwise: go to `FILL`. Drive `mem_en=1`, `mem_write=0`, `mem_addr={cpu tag,index,3'b0}`.
- **WB**
  - Wait at least one cycle, then for `mem_rdy=1`.
  - On completion, switch the outputs to the read request of `FILL` and go to `FILL`.
- **FILL**
  - Wait at least one cycle, then for `mem_rdy=1`.
  - On completion capture `mem_rdata`, drop `mem_en`, go to `REFILL`.
- **REFILL**
  - Write the captured line: valid=1, dirty=0, tag=cpu tag. Go to `IDLE`.
  - The retried access then hits.
- `cpu_stall` = `cpu_en & (state != IDLE | ~hit)`.
- Request fields stay stable while `mem_en=1`.
- `cpu_be=0` on a write hit: completes, data unchanged, dirty still set.
- Byte enables never reach memory; write-back always writes the full line.

## Timing
- Reset values: state `IDLE`, all valid/dirty 0, `mem_en`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, counters 0.
- `cpu_stall` and `cpu_rdata` follow the reset state combinationally.
- Reset mid-`WB`/`FILL`: the transfer is abandoned and `mem_en` is 0 the cycle after the reset edge. A partially written-back line is lost; this is accepted.
- Hit latency: 0 stall cycles.
- Clean miss: `mem_rdy` is never sampled on the first cycle of a request. Stall = 1 (issue) + N (`FILL` cycles until `mem_rdy`) + 1 (`REFILL`) + 0 (hit).
- Dirty miss: adds the `WB` cycles.
- `mem_rdy` is evaluated only in `WB`/`FILL`, after the first cycle of each request.
- `cpu_en` dropping mid-miss: the fill still completes; the cache stays coherent.

## Configuration
- `DDR_CACHE_STATS_EN` defined:
  - `stat_hits` increments on every non-stalled access.
  - `stat_misses` increments on each IDLE→`WB`/`FILL` transition.
  - Both wrap at 2^32 and clear on `rst`.
- Undefined: counters and both ports are absent.

## Structure
- Package `ddr_cache_pkg`: FSM state enum, `LINE_W=256`, `WORD_OFF_W=3`, mem address width 30.
- Sub-module `ddr_cache_array`:
  - Holds valid/dirty/tag/data for all lines.
  - Combinational read by index.
  - One write port: full line on refill, byte-masked word on write hit.
- The FSM and memory interface stay in the top module.

## Test plan
- After reset, read `0x0000_0010` with a memory stub (`mem_rdy` low 5 cycles): one `FILL` at `mem_addr=0x10`, stall 7 cycles, `cpu_rdata` = word 0 of the stub line.
- Write `0xDEADBEEF`, `be=4'b0011` to `0x11` (hit): no stall, no `mem_en`. A following read of `0x11` returns the old upper half with `BEEF` in the low half.
- With `LINES=64`, read `0x210` (same index, new tag): `WB` of the line to `0x10` with the merged data, then `FILL` of `0x210`.
- Assert `rst` during `FILL`: `mem_en`=0 the next cycle. Re-reading `0x10` misses.
- Two back-to-back reads of the same line: one fill, second read 0 stall.
- `DDR_CACHE_STATS_EN`: 3 misses + 5 hits → `stat_misses=3`, `stat_hits=8`, since every access, including each post-refill retry, counts as a hit.
